// File: rtl/ddr3_traffic_checker_if.sv
// Wishbone pipelined bus between the traffic checker (master) and the
// DDR3 controller user port (slave).
interface ddr3_traffic_checker_if #(
  parameter int WB_DATA_BITS = 128,
  parameter int WB_ADDR_BITS = 24
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [WB_ADDR_BITS-1:0]   addr;
  logic [WB_DATA_BITS-1:0]   wdata;
  logic [WB_DATA_BITS/8-1:0] sel;
  logic                      stall;
  logic                      ack;
  logic                      err;
  logic [WB_DATA_BITS-1:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rdata
  );
endinterface

// File: rtl/ddr3_traffic_checker.sv
// Wishbone traffic generator/checker: writes a beat-address range with a
// selectable pattern, reads it back, compares every beat, loops N times.
module ddr3_traffic_checker #(
  parameter int WB_DATA_BITS    = 128,
  parameter int WB_ADDR_BITS    = 24,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ERR_CNT_BITS    = 16,
  parameter int LOOP_BITS       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [1:0]              i_mode,
  input  logic [WB_ADDR_BITS-1:0] i_addr_start,
  input  logic [WB_ADDR_BITS-1:0] i_addr_end,
  input  logic [LOOP_BITS-1:0]    i_loops,
  ddr3_traffic_checker_if.master  wb,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_aborted,
  output logic                    o_cfg_err,
  output logic [ERR_CNT_BITS-1:0] o_err_count,
  output logic [WB_ADDR_BITS-1:0] o_first_err_addr,
  output logic [LOOP_BITS-1:0]    o_loop_count
);
  localparam int NW = WB_DATA_BITS / 32;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int OW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [WB_ADDR_BITS-1:0] start_q, start_d, end_q, end_d, addr_q, addr_d;
  logic [LOOP_BITS-1:0]    loops_q, loops_d, loop_cnt_q, loop_cnt_d;
  logic [OW-1:0]           outst_q, outst_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WB_ADDR_BITS-1:0] fifo_addr_q [MAX_OUTSTANDING];
  logic [WB_ADDR_BITS-1:0] fifo_addr_d [MAX_OUTSTANDING];
  logic                    fifo_we_q   [MAX_OUTSTANDING];
  logic                    fifo_we_d   [MAX_OUTSTANDING];
  logic                    abort_q, abort_d, busy_q, busy_d, done_q, done_d;
  logic                    pass_q, pass_d, aborted_q, aborted_d, cfg_err_q, cfg_err_d;
  logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;
  logic [WB_ADDR_BITS-1:0] first_err_q, first_err_d;

  logic                    issuing, resp, room, stb, accept, cyc, enter_done;
  logic                    pop_we, err_evt;
  logic [WB_ADDR_BITS-1:0] pop_addr;
  logic [WB_DATA_BITS-1:0] wr_beat, exp_beat;

  function automatic logic [WB_DATA_BITS-1:0] gen_beat(
    input logic [WB_ADDR_BITS-1:0] a,
    input logic                    inv,
    input logic [1:0]              m
  );
    logic [WB_DATA_BITS-1:0] beat;
    logic [31:0]             a32, base, x, w;
    beat = '0;
    a32  = 32'(a);
    for (int unsigned k = 0; k < NW; k++) begin
      base = a32 * 32'(NW) + 32'(k);
      x    = base ^ 32'h1234_5678;
      case (m)
        2'd0: w = base;
        2'd1: w = (a32[0] ^ k[0]) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        2'd2: w = 32'h1 << 5'(a32 + 32'(k));
        default: begin
          x = x ^ (x << 13);
          x = x ^ (x >> 17);
          x = x ^ (x << 5);
          w = x;
        end
      endcase
      if (inv) w = ~w;
      beat[32*k +: 32] = w;
    end
    return beat;
  endfunction

  // Issue gating: a same-cycle response frees a slot, so stb may stay high at the limit.
  always_comb begin
    issuing  = ((state_q == S_WRITE) || (state_q == S_READ)) && !abort_q;
    resp     = (wb.ack || wb.err) && (outst_q != '0);
    room     = (outst_q != OW'(MAX_OUTSTANDING)) || resp;
    stb      = issuing && room;
    accept   = stb && !wb.stall;
    cyc      = (state_q == S_WRITE) || (state_q == S_READ) ||
               (((state_q == S_WDRAIN) || (state_q == S_RDRAIN)) && (outst_q != '0));
    pop_we   = fifo_we_q[rd_ptr_q];
    pop_addr = fifo_addr_q[rd_ptr_q];
    wr_beat  = gen_beat(addr_q, loop_cnt_q[0], mode_q);
    exp_beat = gen_beat(pop_addr, loop_cnt_q[0], mode_q);
    err_evt  = resp && (wb.err || (!pop_we && (wb.rdata != exp_beat)));
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    start_d     = start_q;
    end_d       = end_q;
    loops_d     = loops_q;
    addr_d      = addr_q;
    loop_cnt_d  = loop_cnt_q;
    outst_d     = outst_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_addr_d = fifo_addr_q;
    fifo_we_d   = fifo_we_q;
    abort_d     = abort_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    aborted_d   = aborted_q;
    cfg_err_d   = cfg_err_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    enter_done  = 1'b0;

    if (accept) begin
      fifo_addr_d[wr_ptr_q] = addr_q;
      fifo_we_d[wr_ptr_q]   = (state_q == S_WRITE);
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (resp) rd_ptr_d = rd_ptr_q + PW'(1);
    if (accept && !resp)      outst_d = outst_q + OW'(1);
    else if (!accept && resp) outst_d = outst_q - OW'(1);

    if (err_evt) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
      if (err_cnt_q == '0) first_err_d = pop_addr;
    end

    if (busy_q && i_abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          mode_d      = i_mode;
          start_d     = i_addr_start;
          end_d       = i_addr_end;
          loops_d     = i_loops;
          addr_d      = i_addr_start;
          loop_cnt_d  = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          abort_d     = 1'b0;
          pass_d      = 1'b0;
          aborted_d   = 1'b0;
          if (i_addr_end < i_addr_start) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            state_d   = S_WRITE;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
            busy_d    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (abort_q) state_d = S_WDRAIN;
        else if (accept) begin
          if (addr_q == end_q) state_d = S_WDRAIN;
          else addr_d = addr_q + WB_ADDR_BITS'(1);
        end
      end
      S_WDRAIN: begin
        if (outst_q == '0) begin
          if (abort_q) enter_done = 1'b1;
          else begin
            state_d = S_READ;
            addr_d  = start_q;
          end
        end
      end
      S_READ: begin
        if (abort_q) state_d = S_RDRAIN;
        else if (accept) begin
          if (addr_q == end_q) state_d = S_RDRAIN;
          else addr_d = addr_q + WB_ADDR_BITS'(1);
        end
      end
      S_RDRAIN: begin
        if (outst_q == '0) begin
          if (abort_q) enter_done = 1'b1;
          else begin
            loop_cnt_d = loop_cnt_q + LOOP_BITS'(1);
            if ((loops_q != '0) && (loop_cnt_d == loops_q)) enter_done = 1'b1;
            else begin
              state_d = S_WRITE;
              addr_d  = start_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_done) begin
      state_d   = S_DONE;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      aborted_d = abort_q;
      pass_d    = !abort_q && (err_cnt_q == '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      loops_q     <= '0;
      addr_q      <= '0;
      loop_cnt_q  <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_addr_q <= '{default: '0};
      fifo_we_q   <= '{default: 1'b0};
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      end_q       <= end_d;
      loops_q     <= loops_d;
      addr_q      <= addr_d;
      loop_cnt_q  <= loop_cnt_d;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_we_q   <= fifo_we_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
      cfg_err_q   <= cfg_err_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign wb.cyc           = cyc;
  assign wb.stb           = stb;
  assign wb.we            = (state_q == S_WRITE);
  assign wb.addr          = addr_q;
  assign wb.wdata         = (state_q == S_WRITE) ? wr_beat : '0;
  assign wb.sel           = '1;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_pass           = pass_q;
  assign o_aborted        = aborted_q;
  assign o_cfg_err        = cfg_err_q;
  assign o_err_count      = err_cnt_q;
  assign o_first_err_addr = first_err_q;
  assign o_loop_count     = loop_cnt_q;
endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Directed bench: Wishbone slave model with memory, plus a pattern/sequence
// model checked against every accepted request and every read response.
module tb_ddr3_traffic_checker;
  localparam int DB = 128, AB = 24, MAXO = 8, EB = 16, LB = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, abort;
  logic [1:0]    mode;
  logic [AB-1:0] astart, aend;
  logic [LB-1:0] loops;
  logic          busy, done, pass, aborted, cfg_err;
  logic [EB-1:0] err_count;
  logic [AB-1:0] first_err;
  logic [LB-1:0] loop_count;

  ddr3_traffic_checker_if #(.WB_DATA_BITS(DB), .WB_ADDR_BITS(AB)) wb ();

  ddr3_traffic_checker #(
    .WB_DATA_BITS(DB), .WB_ADDR_BITS(AB), .MAX_OUTSTANDING(MAXO),
    .ERR_CNT_BITS(EB), .LOOP_BITS(LB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_mode(mode), .i_addr_start(astart), .i_addr_end(aend), .i_loops(loops),
    .wb(wb),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_aborted(aborted),
    .o_cfg_err(cfg_err), .o_err_count(err_count), .o_first_err_addr(first_err),
    .o_loop_count(loop_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pattern words straight from the spec formulas (NW = 4).
  function automatic logic [31:0] pat_word(input logic [31:0] a, input int k, input int l, input logic [1:0] m);
    logic [31:0] base, x, w;
    base = a * 4 + k;
    case (m)
      2'd0: w = base;
      2'd1: w = (((a + k) % 2) == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      2'd2: w = 32'h1 << ((a + k) % 32);
      default: begin
        x = base ^ 32'h1234_5678;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        w = x;
      end
    endcase
    if (l % 2 == 1) w = ~w;
    return w;
  endfunction

  function automatic logic [DB-1:0] model_beat(input logic [AB-1:0] a, input int l, input logic [1:0] m);
    logic [DB-1:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = pat_word(32'(a), k, l, m);
    return b;
  endfunction

  typedef struct {
    int            due;
    logic          we;
    logic [AB-1:0] a;
    int            l;
    logic [DB-1:0] d;
  } rsp_t;

  rsp_t          rq[$];
  logic [DB-1:0] mem [0:255];
  int            cyc_n = 0;
  int            lat = 1;
  bit            stall_mode = 0, withhold = 0, flip_en = 0, chk_full = 0, no_stb_chk = 0;
  logic [AB-1:0] flip_addr = '0;
  logic          cur_we = 1'b0;
  logic [AB-1:0] cur_a = '0;
  int            cur_l = 0;

  // model state
  logic [AB-1:0] exp_a;
  logic          exp_we;
  int            exp_l, merr, out_m, max_out, acc_cnt;
  logic [AB-1:0] mfirst, cap_addr;
  bit            pend_m, cyc_seen, hold_v;
  logic [AB-1:0] hold_a;
  logic          hold_we;
  logic [DB-1:0] hold_d;
  logic [DB-1:0] cap [0:1];

  // slave response driver
  initial forever begin
    @(posedge clk);
    #1;
    cyc_n++;
    wb.stall = stall_mode && cyc_n[0];
    if (!withhold && rq.size() > 0 && rq[0].due <= cyc_n) begin
      wb.ack = 1'b1;
      wb.rdata = rq[0].d;
      cur_we = rq[0].we;
      cur_a = rq[0].a;
      cur_l = rq[0].l;
      void'(rq.pop_front());
    end else begin
      wb.ack = 1'b0;
      wb.rdata = '0;
    end
  end

  // compare process: slave acceptance, request/response model, per-cycle checks
  initial forever begin
    logic          acc, ackn;
    logic [DB-1:0] rd, fm;
    rsp_t          e;
    @(negedge clk);
    if (!rst_n) begin
      out_m = 0;
      hold_v = 0;
      continue;
    end
    ackn = wb.ack;
    acc = wb.cyc && wb.stb && !wb.stall;
    if (wb.cyc) cyc_seen = 1;
    if (chk_full && !pend_m && out_m == MAXO) check("stb_at_limit", wb.stb, ackn);
    if (no_stb_chk) check("stb_after_abort", wb.stb, 1'b0);
    if (hold_v && wb.stb) begin
      check("stall_addr", wb.addr, hold_a);
      check("stall_we", wb.we, hold_we);
      check("stall_data", wb.wdata, hold_d);
    end
    hold_v = wb.cyc && wb.stb && wb.stall;
    hold_a = wb.addr;
    hold_we = wb.we;
    hold_d = wb.wdata;
    if (ackn && !cur_we) begin
      if (wb.rdata !== model_beat(cur_a, cur_l, mode)) begin
        merr++;
        if (merr == 1) mfirst = cur_a;
      end
    end
    if (acc) begin
      check("req_addr", wb.addr, exp_a);
      check("req_we", wb.we, exp_we);
      rd = '0;
      if (wb.we) begin
        check("wdata", wb.wdata, model_beat(exp_a, exp_l, mode));
        mem[wb.addr[7:0]] = wb.wdata;
        if (wb.addr == cap_addr && exp_l < 2) cap[exp_l] = wb.wdata;
      end else begin
        fm = '0;
        fm[5] = flip_en && (wb.addr == flip_addr);
        rd = mem[wb.addr[7:0]] ^ fm;
      end
      e.due = cyc_n + lat;
      e.we = wb.we;
      e.a = wb.addr;
      e.l = exp_l;
      e.d = rd;
      rq.push_back(e);
      acc_cnt++;
      pend_m = 0;
      if (exp_a == aend) begin
        if (!exp_we) exp_l++;
        exp_we = !exp_we;
        exp_a = astart;
        pend_m = 1;
      end else exp_a = exp_a + 1'b1;
    end
    out_m = out_m + (acc ? 1 : 0) - (ackn ? 1 : 0);
    if (out_m > max_out) max_out = out_m;
  end

  task automatic begin_run(input logic [1:0] m, input logic [AB-1:0] s, input logic [AB-1:0] en, input logic [LB-1:0] n);
    mode = m; astart = s; aend = en; loops = n;
    exp_a = s; exp_we = 1'b1; exp_l = 0; merr = 0; mfirst = '0;
    max_out = 0; acc_cnt = 0; pend_m = 0; cyc_seen = 0; hold_v = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done", done, 1'b1);
  endtask

  task automatic end_checks(input logic exp_pass, input int exp_err, input int exp_loops);
    check("pass", pass, exp_pass);
    check("busy_end", busy, 1'b0);
    check("err_count", err_count, EB'(exp_err));
    check("err_count_model", err_count, EB'(merr));
    check("loop_count", loop_count, LB'(exp_loops));
    check("loop_count_model", loop_count, LB'(exp_l));
    check("outstanding_drained", LB'(out_m), '0);
    check("max_outstanding_ok", (max_out <= MAXO), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0;
    astart = '0; aend = '0; loops = '0;
    wb.stall = 1'b0; wb.ack = 1'b0; wb.err = 1'b0; wb.rdata = '0;
    cap_addr = 24'h10; cap[0] = '0; cap[1] = '0;
    exp_a = '0; exp_we = 1'b1; exp_l = 0; merr = 0; out_m = 0;
    max_out = 0; acc_cnt = 0; pend_m = 0; cyc_seen = 0; hold_v = 0;
    repeat (3) @(negedge clk);
    check("rst_cyc", wb.cyc, 1'b0);
    check("rst_stb", wb.stb, 1'b0);
    check("rst_addr", wb.addr, '0);
    check("rst_wdata", wb.wdata, '0);
    check("rst_status", {busy, done, pass, aborted, cfg_err}, '0);
    check("rst_counts", {err_count, first_err, loop_count}, '0);
    rst_n = 1'b1;

    // 1: mode0 over 0x10..0x13, one loop, ack one cycle after accept
    lat = 1; chk_full = 1;
    begin_run(2'd0, 24'h10, 24'h13, 16'd1);
    wait_done(500);
    end_checks(1'b1, 0, 1);
    check("t1_accepts", acc_cnt, 8);
    check("t1_word0_beat10", cap[0][31:0], 32'h0000_0040);
    check("t1_aborted", aborted, 1'b0);

    // 2: stall every other cycle, 3-cycle ack latency
    stall_mode = 1; lat = 3;
    begin_run(2'd1, 24'h20, 24'h2F, 16'd1);
    wait_done(2000);
    end_checks(1'b1, 0, 1);
    check("t2_accepts", acc_cnt, 32);
    stall_mode = 0;

    // 3: mode2, bit 5 of beat 0x12 flipped on read, two loops
    lat = 1; flip_en = 1; flip_addr = 24'h12;
    begin_run(2'd2, 24'h10, 24'h13, 16'd2);
    wait_done(1000);
    end_checks(1'b0, 2, 2);
    check("t3_first_err", first_err, 24'h12);
    check("t3_loop0_word0", cap[0][31:0], 32'h0001_0000);
    check("t3_loop1_word0", cap[1][31:0], 32'hFFFE_FFFF);
    check("t3_loop1_inverted", cap[1], ~cap[0]);
    flip_en = 0;

    // 4: acks withheld -> exactly MAXO accepts, resume with the first ack
    withhold = 1;
    begin_run(2'd0, 24'h00, 24'h1F, 16'd1);
    n = 0;
    while (acc_cnt < MAXO && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("t4_accepts_at_limit", acc_cnt, MAXO);
    check("t4_stb_held_low", wb.stb, 1'b0);
    check("t4_cyc_held", wb.cyc, 1'b1);
    withhold = 0;
    @(negedge clk);
    check("t4_ack_resume", wb.ack, 1'b1);
    check("t4_stb_resume", wb.stb, 1'b1);
    wait_done(2000);
    end_checks(1'b1, 0, 1);
    check("t4_max_out", max_out, MAXO);
    chk_full = 0;

    // 5: endless mode3 run, abort in the READ phase of loop 1
    lat = 3;
    begin_run(2'd3, 24'h00, 24'h07, 16'd0);
    n = 0;
    while (acc_cnt < 25 && n < 1000) begin @(negedge clk); n++; end
    check("t5_reached_read", acc_cnt >= 25, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); no_stb_chk = 1;
    wait_done(500);
    no_stb_chk = 0;
    check("t5_aborted", aborted, 1'b1);
    check("t5_pass", pass, 1'b0);
    check("t5_loop_count", loop_count, LB'(1));
    check("t5_err_count", err_count, EB'(merr));
    check("t5_drained", LB'(out_m), '0);
    check("t5_no_pending_rsp", rq.size(), 0);
    check("t5_cyc_low", wb.cyc, 1'b0);
    abort = 1'b0;

    // 6: end below start -> config error, no bus traffic
    lat = 1;
    begin_run(2'd0, 24'h05, 24'h03, 16'd1);
    check("t6_done_next", done, 1'b1);
    check("t6_cfg_err", cfg_err, 1'b1);
    check("t6_pass", pass, 1'b0);
    check("t6_aborted_cleared", aborted, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_no_cyc", cyc_seen, 1'b0);

    // 7: reset pulse during the WRITE phase
    begin_run(2'd0, 24'h00, 24'h1F, 16'd1);
    n = 0;
    while (acc_cnt < 4 && n < 100) begin @(negedge clk); n++; end
    check("t7_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_cyc", wb.cyc, 1'b0);
    check("t7_stb", wb.stb, 1'b0);
    check("t7_status", {busy, done, pass, aborted, cfg_err}, '0);
    check("t7_counts", {err_count, first_err, loop_count}, '0);
    rq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
